// File: rtl/credits_scroll_ctrl.sv
// Purpose: sequences the credits overlay (scroll up, hold, fade foreground, finish) one step per frame.
// Latency: a vblank rising edge sampled at clock N shows its effect on the outputs from N+1.
// Backpressure: none; outputs are registered levels, updated only on vblank-start frame ticks.
module credits_scroll_ctrl #(
    parameter logic [11:0] X_POS       = 12'd448,
    parameter logic [11:0] START_Y     = 12'd768,
    parameter logic [11:0] STOP_Y      = 12'd336,
    parameter logic [11:0] STEP        = 12'd2,
    parameter logic [15:0] HOLD_FRAMES = 16'd180,
    parameter logic [11:0] COLOR_FG    = 12'hFFF,
    parameter logic [11:0] COLOR_BG    = 12'h000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic        skip,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [11:0] color1,
    output logic [11:0] color2,
    output logic        active,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCROLL = 3'd1,
        S_HOLD   = 3'd2,
        S_FADE   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Threshold at or below which the next step would land on or past the stop line.
    localparam logic [11:0] SNAP_Y    = STOP_Y + STEP;
    localparam logic [15:0] HOLD_LAST = HOLD_FRAMES - 16'd1;

    state_t      state;
    logic        pending;
    logic        vblnk_prev;
    logic [15:0] frame_cnt;
    logic        tick;
    logic [11:0] faded;

    // One step toward black: every 4-bit channel drops by one, stopping at zero.
    function automatic logic [11:0] fade_step(input logic [11:0] c);
        logic [11:0] r;
        r = 12'h000;
        for (int i = 0; i < 3; i++) begin
            if (c[i*4 +: 4] != 4'h0) begin
                r[i*4 +: 4] = c[i*4 +: 4] - 4'h1;
            end
        end
        return r;
    endfunction

    // Frame tick is the first cycle vblank is seen high; a held-high vblank yields one tick.
    assign tick  = vblnk_in & ~vblnk_prev;
    assign faded = fade_step(color2);

    // Sequencer: all state and outputs move together on the frame tick, except the
    // single-cycle DONE state which restores the parked overlay on its own.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            vblnk_prev <= 1'b0;
            frame_cnt  <= 16'd0;
            xpos       <= X_POS;
            ypos       <= START_Y;
            color1     <= COLOR_BG;
            color2     <= COLOR_FG;
            active     <= 1'b0;
            done       <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            case (state)
                S_IDLE: begin
                    // A start arriving on the tick cycle is consumed directly; skip is ignored here.
                    if (tick && (start || pending)) begin
                        ypos    <= START_Y;
                        color2  <= COLOR_FG;
                        active  <= 1'b1;
                        pending <= 1'b0;
                        state   <= S_SCROLL;
                    end else if (start) begin
                        pending <= 1'b1;
                    end
                end
                S_SCROLL: begin
                    if (tick) begin
                        if (skip) begin
                            done   <= 1'b1;
                            active <= 1'b0;
                            state  <= S_DONE;
                        end else if (ypos <= SNAP_Y) begin
                            // Unsigned compare before subtracting keeps ypos from wrapping.
                            ypos      <= STOP_Y;
                            frame_cnt <= 16'd0;
                            state     <= S_HOLD;
                        end else begin
                            ypos <= ypos - STEP;
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        if (skip) begin
                            done   <= 1'b1;
                            active <= 1'b0;
                            state  <= S_DONE;
                        end else if (frame_cnt == HOLD_LAST) begin
                            state <= S_FADE;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                S_FADE: begin
                    if (tick) begin
                        if (skip) begin
                            done   <= 1'b1;
                            active <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            color2 <= faded;
                            if (faded == 12'h000) begin
                                done   <= 1'b1;
                                active <= 1'b0;
                                state  <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // done is high for exactly this cycle; park the overlay again.
                    done   <= 1'b0;
                    active <= 1'b0;
                    ypos   <= START_Y;
                    color2 <= COLOR_FG;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_credits_scroll_ctrl.sv
module tb_credits_scroll_ctrl;

    localparam logic [11:0] FG_A = 12'hFFF;
    localparam logic [11:0] FG_B = 12'hF30;
    localparam int START = 20;
    localparam int STOP  = 10;
    localparam int STP   = 3;
    localparam int HOLDN = 2;
    localparam int NS    = (START - STOP + STP - 1) / STP;  // scroll ticks to reach STOP
    localparam int NF    = 15;                              // fade ticks for a max nibble of F
    localparam int T_END = NS + HOLDN + NF;

    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic vblnk = 1'b0;
    logic start = 1'b0;
    logic skip = 1'b0;

    logic [11:0] xpos_a, ypos_a, color1_a, color2_a;
    logic [11:0] xpos_b, ypos_b, color1_b, color2_b;
    logic        active_a, done_a, active_b, done_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 pclk = ~pclk;

    credits_scroll_ctrl #(
        .START_Y(12'd20), .STOP_Y(12'd10), .STEP(12'd3), .HOLD_FRAMES(16'd2), .COLOR_FG(FG_A)
    ) dut_a (
        .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .start(start), .skip(skip),
        .xpos(xpos_a), .ypos(ypos_a), .color1(color1_a), .color2(color2_a),
        .active(active_a), .done(done_a)
    );

    credits_scroll_ctrl #(
        .START_Y(12'd20), .STOP_Y(12'd10), .STEP(12'd3), .HOLD_FRAMES(16'd2), .COLOR_FG(FG_B)
    ) dut_b (
        .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .start(start), .skip(skip),
        .xpos(xpos_b), .ypos(ypos_b), .color1(color1_b), .color2(color2_b),
        .active(active_b), .done(done_b)
    );

    // Colour after n fade steps: each nibble reduced by n, floored at zero.
    function automatic logic [11:0] faded(input logic [11:0] fg, input int n);
        logic [11:0] r;
        int v;
        r = 12'h000;
        for (int i = 0; i < 3; i++) begin
            v = int'(fg[i*4 +: 4]) - n;
            if (v < 0) v = 0;
            r[i*4 +: 4] = 4'(v);
        end
        return r;
    endfunction

    // Y position t ticks after launch: straight-line climb, then parked at STOP.
    function automatic int y_at(input int t);
        return (t >= NS) ? STOP : START - t * STP;
    endfunction

    // Number of fade steps applied t ticks after launch.
    function automatic int f_at(input int t);
        int f;
        f = t - NS - HOLDN;
        if (f < 0) f = 0;
        if (f > NF) f = NF;
        return f;
    endfunction

    // Behavioural model: a sequence is "ticks since launch"; outputs follow from that count.
    bit m_vprev = 0, m_run = 0, m_pend = 0, m_donep = 0;
    int m_t = 0;
    int e_ypos = START;
    int e_fcnt = 0;
    bit e_active = 0, e_done = 0;

    always @(posedge pclk) begin
        bit tk;
        tk = vblnk & ~m_vprev;
        m_vprev = vblnk;
        if (rst) begin
            m_vprev = 0; m_run = 0; m_pend = 0; m_donep = 0; m_t = 0;
            e_ypos = START; e_fcnt = 0; e_active = 0; e_done = 0;
        end else if (m_donep) begin
            m_donep = 0; e_done = 0; e_ypos = START; e_fcnt = 0;
        end else if (!m_run) begin
            if (tk && (start || m_pend)) begin
                m_run = 1; m_t = 0; m_pend = 0;
                e_active = 1; e_ypos = START; e_fcnt = 0;
            end else if (start) begin
                m_pend = 1;
            end
        end else if (tk) begin
            if (skip) begin
                m_run = 0; m_donep = 1; e_done = 1; e_active = 0;
            end else begin
                m_t++;
                e_ypos = y_at(m_t);
                e_fcnt = f_at(m_t);
                if (m_t == T_END) begin
                    m_run = 0; m_donep = 1; e_done = 1; e_active = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge pclk) begin
        if (chk_en) begin
            chk("cmp_xpos_a",   32'(xpos_a),   32'd448);
            chk("cmp_color1_a", 32'(color1_a), 32'h000);
            chk("cmp_ypos_a",   32'(ypos_a),   32'(e_ypos));
            chk("cmp_color2_a", 32'(color2_a), 32'(faded(FG_A, e_fcnt)));
            chk("cmp_active_a", 32'(active_a), 32'(e_active));
            chk("cmp_done_a",   32'(done_a),   32'(e_done));
            chk("cmp_ypos_b",   32'(ypos_b),   32'(e_ypos));
            chk("cmp_color2_b", 32'(color2_b), 32'(faded(FG_B, e_fcnt)));
            chk("cmp_active_b", 32'(active_b), 32'(e_active));
            chk("cmp_done_b",   32'(done_b),   32'(e_done));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic tick_only();
        vblnk = 1'b1; cyc(1);
        vblnk = 1'b0; cyc(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(1);
    endtask

    initial begin
        int hi, lo;
        rst = 1'b1;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("rst_ypos", 32'(ypos_a), 32'd20);
        chk("rst_color2_a", 32'(color2_a), 32'hFFF);
        chk("rst_color2_b", 32'(color2_b), 32'hF30);
        chk("rst_active", 32'(active_a), 32'd0);
        cyc(1);

        // Tick with nothing pending stays parked.
        tick_only();
        chk("idle_tick_active", 32'(active_a), 32'd0);

        // Launch: start pulse, then vblank held high for 50 cycles.
        pulse_start();
        vblnk = 1'b1; cyc(1);
        chk("launch_active", 32'(active_a), 32'd1);
        chk("launch_ypos", 32'(ypos_a), 32'd20);
        cyc(49);
        vblnk = 1'b0; cyc(2);
        chk("held_vblnk_ypos", 32'(ypos_a), 32'd20);
        tick_only();
        chk("scroll_y1", 32'(ypos_a), 32'd17);
        pulse_start();  // ignored while running
        tick_only();
        chk("scroll_y2", 32'(ypos_a), 32'd14);
        tick_only();
        chk("scroll_y3", 32'(ypos_a), 32'd11);
        tick_only();
        chk("scroll_y4", 32'(ypos_a), 32'd10);
        tick_only(); tick_only();
        chk("hold_ypos", 32'(ypos_a), 32'd10);
        chk("hold_color", 32'(color2_a), 32'hFFF);
        tick_only();
        chk("fade1_a", 32'(color2_a), 32'hEEE);
        chk("fade1_b", 32'(color2_b), 32'hE20);
        repeat (7) tick_only();
        chk("fade8_a", 32'(color2_a), 32'h777);
        chk("fade8_b", 32'(color2_b), 32'h700);

        // Reset in the middle of the fade.
        rst = 1'b1; cyc(1);
        rst = 1'b0;
        chk("midrst_color2", 32'(color2_a), 32'hFFF);
        chk("midrst_ypos", 32'(ypos_a), 32'd20);
        chk("midrst_active", 32'(active_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        cyc(1);
        tick_only();
        chk("postrst_idle", 32'(active_a), 32'd0);

        // start and skip together on the tick: start wins.
        start = 1'b1; skip = 1'b1; vblnk = 1'b1; cyc(1);
        start = 1'b0; skip = 1'b0;
        chk("start_skip_active", 32'(active_a), 32'd1);
        vblnk = 1'b0; cyc(2);
        pulse_start();
        repeat (NS + HOLDN + NF - 1) tick_only();
        chk("fade14_a", 32'(color2_a), 32'h111);
        chk("fade14_b", 32'(color2_b), 32'h100);
        vblnk = 1'b1; cyc(1);
        chk("end_done", 32'(done_a), 32'd1);
        chk("end_active", 32'(active_a), 32'd0);
        chk("end_color2", 32'(color2_a), 32'h000);
        vblnk = 1'b0; cyc(1);
        chk("after_done", 32'(done_a), 32'd0);
        chk("after_ypos", 32'(ypos_a), 32'd20);
        chk("after_color2_b", 32'(color2_b), 32'hF30);
        cyc(2);
        tick_only();
        chk("no_retrigger", 32'(active_a), 32'd0);

        // Skip during HOLD.
        pulse_start();
        repeat (1 + NS + 1) tick_only();
        skip = 1'b1; vblnk = 1'b1; cyc(1);
        skip = 1'b0;
        chk("skip_done", 32'(done_a), 32'd1);
        chk("skip_active", 32'(active_a), 32'd0);
        vblnk = 1'b0; cyc(1);
        chk("skip_ypos", 32'(ypos_a), 32'd20);
        chk("skip_color2", 32'(color2_a), 32'hFFF);
        cyc(2);
        skip = 1'b1; vblnk = 1'b1; cyc(1);
        skip = 1'b0;
        chk("idle_skip_active", 32'(active_a), 32'd0);
        chk("idle_skip_done", 32'(done_a), 32'd0);
        vblnk = 1'b0; cyc(2);

        // Randomised frames, starts, skips and occasional resets.
        for (int f = 0; f < 700; f++) begin
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 5);
            for (int c = 0; c < hi + lo; c++) begin
                vblnk = (c < hi);
                start = ($urandom_range(0, 24) == 0);
                skip  = ($urandom_range(0, 149) == 0);
                rst   = ($urandom_range(0, 999) == 0);
                cyc(1);
            end
        end
        start = 1'b0; skip = 1'b0; rst = 1'b0; vblnk = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/credits_scroll_ctrl.md
Name: credits_scroll_ctrl

Overview:
- Frame-synchronous controller that sequences the credits text overlay.
- Drives the overlay's position (xpos, ypos) and colours (color1, color2) from a state machine: scroll up from off-screen, hold, fade the foreground to black, finish.
- Sits beside the credits character-draw stage in the VGA pipeline and takes its timing from the vertical-blank signal.
- All output updates occur only at the start of vertical blanking, so nothing tears mid-frame.

Parameters:
- X_POS, 12'd448: constant horizontal position of the text block.
- START_Y, 12'd768: parked/off-screen Y, and the Y loaded when scrolling starts.
- STOP_Y, 12'd336: final Y of the scroll.
- STEP, 12'd2: pixels moved up per frame.
- HOLD_FRAMES, 16'd180: number of frames held at STOP_Y.
- COLOR_FG, 12'hFFF: initial text (foreground) colour, driven on color2.
- COLOR_BG, 12'h000: box background colour, driven on color1.

Ports:
- pclk, input, 1: pixel clock.
- rst, input, 1: synchronous, active-high reset.
- vblnk_in, input, 1: vertical blank from the timing pipeline.
- start, input, 1: request to run the credits sequence (level or pulse).
- skip, input, 1: abort the running sequence.
- xpos, output, 12: overlay X.
- ypos, output, 12: overlay Y.
- color1, output, 12: overlay background colour.
- color2, output, 12: overlay text colour.
- active, output, 1: high while the sequence runs (SCROLL/HOLD/FADE).
- done, output, 1: one-cycle pulse when the sequence ends.

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock pclk. All state and outputs are registered.
- Reset values:
  - state = IDLE, pending = 0, vblnk_prev = 0, frame_cnt = 0.
  - xpos = X_POS, ypos = START_Y, color1 = COLOR_BG, color2 = COLOR_FG, active = 0, done = 0.
- Frame tick:
  - tick = vblnk_in & ~vblnk_prev, where vblnk_prev is registered every cycle.
  - State and output changes caused by a tick are visible on the cycle after the vblnk rising edge is sampled (latency 1).
- xpos and color1 are constant at their parameter values after reset.
- IDLE:
  - start = 1 sets pending.
  - On a tick with pending = 1: ypos <= START_Y, color2 <= COLOR_FG, active <= 1, pending <= 0, go to SCROLL.
  - If start and the tick occur in the same cycle, the tick consumes the start in that cycle (start-or-pending).
- SCROLL, on each tick:
  - If ypos <= STOP_Y + STEP: ypos <= STOP_Y, frame_cnt <= 0, go to HOLD.
  - Else: ypos <= ypos - STEP.
  - The comparison is unsigned 12-bit, which prevents underflow.
- HOLD, on each tick:
  - If frame_cnt == HOLD_FRAMES-1: go to FADE.
  - Else: frame_cnt <= frame_cnt + 1.
- FADE, on each tick:
  - Each 4-bit nibble of color2 is decremented by 1, saturating at 0.
  - If the decremented value is 12'h000: go to DONE.
  - With the default colours, 15 ticks take FFF to 000.
- DONE (exactly one pclk):
  - done = 1, active <= 0, ypos <= START_Y, color2 <= COLOR_FG, then IDLE.
  - done is low in every other state.
- skip:
  - If skip = 1 on a tick in SCROLL, HOLD or FADE, go to DONE. skip takes priority over that state's normal update.
  - skip is ignored in IDLE and DONE.
  - If start and skip are high together in IDLE, start is honoured and skip is ignored.
- start while active: ignored, and pending is not set.
- Ticks without pending in IDLE: no change.
- Reset mid-operation: every register returns to its reset value on the next clock edge, regardless of state.
- A vblnk_in held high produces only one tick.

Test Plan:
- Small-parameter scroll: START_Y=20, STOP_Y=10, STEP=3, HOLD_FRAMES=2. Pulse start, then generate vblnk edges. Required:
  - ypos sequence 20, 17, 14, 11, 10.
  - HOLD for 2 ticks.
  - FADE color2 FFF→EEE→…→000 over 15 ticks.
  - One-cycle done, then active=0, ypos=20, color2=FFF.
- Tick latency: start pulse, then a vblnk rising edge at cycle N. Required: active=1 and ypos=START_Y at N+1. With vblnk held high for 50 cycles, ypos changes only once.
- Skip: skip asserted during HOLD on a tick. Required: done pulses on the next cycle, active drops, ypos returns to START_Y, color2 returns to FFF. A skip pulse during IDLE produces no change.
- Start/skip arbitration: start=1 and skip=1 together in IDLE, then a tick. Required: SCROLL entered with active=1. A start during SCROLL does not retrigger after done.
- Reset mid-FADE with color2=12'h777: assert rst for one cycle. Required: color2=FFF, ypos=START_Y, active=0, done=0. A tick without a new start keeps the block in IDLE.
- Saturation: COLOR_FG=12'hF30. Required: fade sequence F30, E20, D10, C00, B00, …, 000; DONE is entered after 15 ticks.
